// File: rtl/master_tx_ltssm.sv
// master_tx_ltssm: transmit-side LTSSM helper.
// For each substate requested by the main LTSSM, selects the ordered-set type
// to transmit, drives transmitter electrical idle and receiver-detect request,
// counts ordered sets actually sent and pulses finish once both the TX count
// requirement and the RX-side completion have been met.
// Ports:
//   clk, reset (async, active-low)
//   substate        requested substate (0..10 defined, 11..15 ignored)
//   osSent          pulse per ordered set completed on all active lanes
//   rxFinish        pulse: RX condition met for current substate
//   detectDone      pulse: receiver detection finished
//   detectedLanes   detected lane count, valid with detectDone
//   finish          pulse: TX requirement of current substate met
//   osType          0 none, 1 TS1, 2 TS2, 3 logical IDLE
//   sendOS          OS generator enable
//   txElecIdle      transmitter electrical idle
//   detectReq       receiver-detect request pulse
//   lanesDetected   latched detectedLanes
module master_tx_ltssm #(
  parameter int unsigned MAXLANES = 16,
  localparam int unsigned LW = $clog2(MAXLANES + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [3:0]    substate,
  input  logic          osSent,
  input  logic          rxFinish,
  input  logic          detectDone,
  input  logic [LW-1:0] detectedLanes,
  output logic          finish,
  output logic [1:0]    osType,
  output logic          sendOS,
  output logic          txElecIdle,
  output logic          detectReq,
  output logic [LW-1:0] lanesDetected
);

  localparam int unsigned CW = 11;
  localparam logic [CW-1:0] CNT_MAX = CW'(2047);

  localparam logic [3:0] SUB_QUIET  = 4'd0;
  localparam logic [3:0] SUB_ACTIVE = 4'd1;
  localparam logic [3:0] SUB_CFGIDL = 4'd9;
  localparam logic [3:0] SUB_L0     = 4'd10;

  localparam logic [1:0] OS_NONE = 2'd0;
  localparam logic [1:0] OS_TS1  = 2'd1;
  localparam logic [1:0] OS_TS2  = 2'd2;
  localparam logic [1:0] OS_IDLE = 2'd3;

  typedef enum logic [1:0] {IDLE, SEND, WAIT, DONE} state_t;

  state_t        state, state_n;
  logic [3:0]    last_sub, last_sub_n;
  logic [3:0]    cur_sub, cur_sub_n;
  logic [1:0]    ld_type, ld_type_n;
  logic [CW-1:0] req, req_n;
  logic          gated, gated_n;
  logic [CW-1:0] tx_count, tx_count_n;
  logic          rx_seen, rx_seen_n;
  logic          finish_n, send_os_n, tx_elec_idle_n, detect_req_n;
  logic [1:0]    os_type_n;
  logic [LW-1:0] lanes_n;

  logic [1:0]    tbl_type;
  logic [CW-1:0] tbl_req;
  logic          tbl_gated;
  logic          rx_seen_nx;
  logic          count_en;
  logic [CW-1:0] cnt_nx;

  // Per-substate transmit table: OS type, required count, count gated by rxSeen.
  always_comb begin
    tbl_type  = OS_NONE;
    tbl_req   = '0;
    tbl_gated = 1'b0;
    case (substate)
      4'd2: begin tbl_type = OS_TS1; tbl_req = CW'(1024); end
      4'd3: begin tbl_type = OS_TS2; tbl_req = CW'(16); tbl_gated = 1'b1; end
      4'd4, 4'd5, 4'd6, 4'd7: tbl_type = OS_TS1;
      4'd8: begin tbl_type = OS_TS2; tbl_req = CW'(16); tbl_gated = 1'b1; end
      4'd9: begin tbl_type = OS_IDLE; tbl_req = CW'(16); tbl_gated = 1'b1; end
      default: ;
    endcase
  end

  // Same-cycle view of rxSeen/count so an rxFinish coinciding with osSent
  // lets that osSent count, and exit is decided on the updated values.
  always_comb begin
    rx_seen_nx = rx_seen | rxFinish;
    count_en   = osSent & (~gated | rx_seen_nx);
    cnt_nx     = (count_en && (tx_count != CNT_MAX)) ? CW'(tx_count + CW'(1)) : tx_count;
  end

  // Next-state and next-output logic.
  always_comb begin
    state_n        = state;
    last_sub_n     = last_sub;
    cur_sub_n      = cur_sub;
    ld_type_n      = ld_type;
    req_n          = req;
    gated_n        = gated;
    tx_count_n     = tx_count;
    rx_seen_n      = rx_seen;
    finish_n       = 1'b0;
    os_type_n      = osType;
    send_os_n      = sendOS;
    tx_elec_idle_n = txElecIdle;
    detect_req_n   = 1'b0;
    lanes_n        = lanesDetected;

    case (state)
      IDLE: begin
        if (substate == SUB_L0) begin
          os_type_n      = OS_NONE;
          send_os_n      = 1'b0;
          tx_elec_idle_n = 1'b0;
        end else if ((substate != last_sub) && (substate <= SUB_CFGIDL)) begin
          cur_sub_n  = substate;
          ld_type_n  = tbl_type;
          req_n      = tbl_req;
          gated_n    = tbl_gated;
          tx_count_n = '0;
          rx_seen_n  = 1'b0;
          // Type switches at load so an ongoing transmission moves to the new OS.
          os_type_n  = tbl_type;
          state_n    = SEND;
        end
      end
      SEND: begin
        if (substate != cur_sub) begin
          state_n = IDLE;
        end else if (cur_sub == SUB_QUIET) begin
          tx_elec_idle_n = 1'b1;
          send_os_n      = 1'b0;
          state_n        = DONE;
        end else if (cur_sub == SUB_ACTIVE) begin
          tx_elec_idle_n = 1'b1;
          send_os_n      = 1'b0;
          detect_req_n   = 1'b1;
          state_n        = WAIT;
        end else begin
          tx_elec_idle_n = 1'b0;
          send_os_n      = 1'b1;
          os_type_n      = ld_type;
          rx_seen_n      = rx_seen_nx;
          tx_count_n     = cnt_nx;
          if (rx_seen_nx && (cnt_nx >= req)) state_n = DONE;
        end
      end
      WAIT: begin
        if (substate != cur_sub) begin
          state_n = IDLE;
        end else if (detectDone) begin
          lanes_n = detectedLanes;
          state_n = DONE;
        end
      end
      DONE: begin
        finish_n   = 1'b1;
        last_sub_n = cur_sub;
        state_n    = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      last_sub      <= 4'hF;
      cur_sub       <= 4'hF;
      ld_type       <= OS_NONE;
      req           <= '0;
      gated         <= 1'b0;
      tx_count      <= '0;
      rx_seen       <= 1'b0;
      finish        <= 1'b0;
      osType        <= OS_NONE;
      sendOS        <= 1'b0;
      txElecIdle    <= 1'b1;
      detectReq     <= 1'b0;
      lanesDetected <= '0;
    end else begin
      state         <= state_n;
      last_sub      <= last_sub_n;
      cur_sub       <= cur_sub_n;
      ld_type       <= ld_type_n;
      req           <= req_n;
      gated         <= gated_n;
      tx_count      <= tx_count_n;
      rx_seen       <= rx_seen_n;
      finish        <= finish_n;
      osType        <= os_type_n;
      sendOS        <= send_os_n;
      txElecIdle    <= tx_elec_idle_n;
      detectReq     <= detect_req_n;
      lanesDetected <= lanes_n;
    end
  end

endmodule

// File: doc/master_tx_ltssm.md
# master_tx_ltssm

Transmit-side counterpart of the master RX LTSSM. For each substate the main LTSSM requests, this block selects the ordered-set type to transmit and drives transmit electrical idle and the receiver-detect request. It counts ordered sets actually sent by the OS generator and pulses `finish` once the substate's transmit requirement and the RX-side completion are both met. Sits between the main LTSSM (substate in, finish out) and the per-lane OS generator (type/valid out, sent pulse in).

## Interface
- `MAXLANES`, 16: maximum lane count; sizes the lane-count port only.
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-low.
- `substate`  in  4  requested substate. Encoding: 0 detectQuiet, 1 detectActive, 2 pollingActive, 3 pollingConfiguration, 4 cfgLinkWidthStart, 5 cfgLinkWidthAccept, 6 cfgLanenumWait, 7 cfgLanenumAccept, 8 cfgComplete, 9 cfgIdle, 10 L0.
- `osSent`  in  1  one-cycle pulse per ordered set completed on all active lanes.
- `rxFinish`  in  1  one-cycle pulse from RX LTSSM: RX condition met for current substate.
- `detectDone`  in  1  one-cycle pulse: PHY receiver detection finished.
- `detectedLanes`  in  5  lanes detected; valid with `detectDone`.
- `finish`  out  1  one-cycle pulse: TX requirement of current substate met.
- `osType`  out  2  0 none, 1 TS1, 2 TS2, 3 logical IDLE.
- `sendOS`  out  1  OS generator enable; `osType` valid while high.
- `txElecIdle`  out  1  transmitter electrical idle.
- `detectReq`  out  1  one-cycle receiver-detect request pulse.
- `lanesDetected`  out  5  latched `detectedLanes`.

## Operation
- FSM states: IDLE, SEND, WAIT, DONE. All outputs are registered.
- Reset values: state IDLE, `lastSub`=4'hF, `finish`=0, `osType`=0, `sendOS`=0, `txElecIdle`=1, `detectReq`=0, `lanesDetected`=0, `txCount`=0, `rxSeen`=0.
- IDLE: when `substate` != `lastSub` and `substate` <= 9, load the per-substate table, clear `txCount` and `rxSeen`, and go to SEND. For `substate`=10 (L0): `osType`=0, `sendOS`=0, `txElecIdle`=0, and stay in IDLE. For values 11–15: stay in IDLE with outputs unchanged.
- Per-substate table (osType / required count N / count gated by rxSeen):
  - 2: TS1 / 1024 / no.
  - 3: TS2 / 16 / yes.
  - 4, 5, 6, 7: TS1 / 0 / no.
  - 8: TS2 / 16 / yes.
  - 9: IDLE / 16 / yes.
- detectQuiet (0): `txElecIdle`=1, `sendOS`=0. Go straight to DONE.
- detectActive (1): `txElecIdle`=1, `sendOS`=0, pulse `detectReq` for one cycle on entry, then go to WAIT. On `detectDone`: latch `lanesDetected` and go to DONE.
- SEND (substates 2–9): `txElecIdle`=0, `sendOS`=1, `osType` from table.
  - `rxFinish` sets sticky `rxSeen`.
  - `osSent` increments `txCount` (11-bit, saturating at 2047) only when the count is not gated or `rxSeen`=1.
  - Exit to DONE when `rxSeen`=1 and `txCount` >= N.
- DONE: pulse `finish`, set `lastSub`=`substate`, return to IDLE. `sendOS` and `osType` hold their values so transmission continues until the next substate is loaded.
- Abort: if `substate` changes while in SEND or WAIT, go to IDLE next cycle with no `finish` and `lastSub` unchanged. The new substate then loads normally.
- `osSent` or `rxFinish` pulses while in IDLE or DONE are ignored.
- A `substate` equal to `lastSub` never restarts the FSM (same-request guard). Async reset clears the guard.

## Timing
- Entry latency: `substate` change at cycle 0 → state SEND at cycle 1 → `sendOS`/`osType` visible at cycle 2.
- `finish` rises 2 cycles after the qualifying event (the `osSent` that reaches N, or `rxFinish` when the count is already met) and is high for exactly 1 cycle.
- Simultaneous `osSent` and `rxFinish` in a gated substate: `rxSeen` is set and that same `osSent` counts.
- N=0 substates: `finish` follows `rxFinish` by 2 cycles, independent of `osSent`.
- detectQuiet: `finish` at cycle 3 after the substate change.
- detectActive: `detectReq` high at cycle 2; `finish` 2 cycles after `detectDone`.
- Reset mid-operation: all outputs return to reset values immediately (asynchronous).

## Test plan
- Reset, then substate=0 → `txElecIdle`=1, `sendOS`=0, one `finish` pulse at cycle 3; holding substate=0 produces no further `finish`.
- substate=1, then `detectDone` with `detectedLanes`=8 → one `detectReq` pulse, `lanesDetected`=8, one `finish`.
- substate=2, `rxFinish` early, 1023 `osSent` pulses → no `finish`; the 1024th `osSent` → `finish` 2 cycles later, `osType`=1 throughout.
- substate=3, 20 `osSent` before `rxFinish`, then 16 `osSent` after → `finish` only on the 16th post-`rxFinish` pulse, `osType`=2.
- substate=9 with 5 `osSent` counted, substate changed to 4 → no `finish`, `osType`=1 by cycle 2; `rxFinish` → `finish`.
- Async reset asserted during substate=8 with `txCount`=10 → all outputs at reset values; after release, substate=8 restarts with `txCount`=0.
